// File: rtl/word72_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : word72_stream_ctrl
// Description : Streaming FIFO controller for a dual-port 128-bit SRAM
//               (word72 wrapper). Port A is used only for writes and port B
//               only for reads. A 2-entry output stage (head + skid) absorbs
//               the one-cycle SRAM read latency, which sustains 1 word/cycle.
//
//   clk, rst            : single clock, synchronous active-high reset
//   flush               : synchronous clear of all queued data
//   in_valid/ready/data : upstream write stream (128 bits)
//   out_valid/ready/data: downstream read stream (128 bits)
//   level               : words in SRAM + read in flight + output stage
//   sram_a/wean/dia/oea : SRAM port A (write only)
//   sram_b/webn/dib/oeb : SRAM port B (read only), sram_dob returns next cycle
//
// Revision    : 1.0 - initial release
// ============================================================================
module word72_stream_ctrl #(
    parameter int DEPTH = 72
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [6:0]   level,
    output logic [6:0]   sram_a,
    output logic [7:0]   sram_wean,
    output logic [127:0] sram_dia,
    output logic         sram_oea,
    output logic [6:0]   sram_b,
    output logic [7:0]   sram_webn,
    output logic [127:0] sram_dib,
    output logic         sram_oeb,
    input  logic [127:0] sram_dob
);

    localparam logic [6:0] c_ptr_last = 7'(DEPTH - 1);
    localparam logic [7:0] c_depth    = 8'(DEPTH);

    logic [6:0]   r_wr_ptr, r_rd_ptr;
    logic [7:0]   r_sram_cnt;
    logic         r_inflight;
    logic [1:0]   r_out_occ;
    logic [127:0] r_head, r_skid;
    logic [6:0]   r_level;

    logic         w_in_ready, w_wr, w_pop, w_rd;
    logic [2:0]   w_stage;
    logic [6:0]   w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [7:0]   w_cnt_nxt;
    logic         w_inflight_nxt;
    logic [1:0]   w_occ_nxt;
    logic [127:0] w_head_nxt, w_skid_nxt;
    logic [6:0]   w_level_nxt;

    assign w_in_ready = (r_sram_cnt < c_depth) && !flush && !rst;
    assign w_wr       = in_valid && w_in_ready;
    assign w_pop      = (r_out_occ != 2'd0) && out_ready && !rst;
    // Words already committed to the output path after this cycle's pop.
    // A new read is only issued if its data is guaranteed a free slot.
    assign w_stage    = {2'b00, r_inflight} + {1'b0, r_out_occ} - {2'b00, w_pop};
    // Reads may issue during a flush; their data is dropped because the
    // flush clears the inflight flag before sram_dob would be captured.
    assign w_rd       = (r_sram_cnt != 8'd0) && (w_stage < 3'd2) && !rst;

    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_cnt_nxt      = r_sram_cnt + {7'd0, w_wr} - {7'd0, w_rd};
        w_inflight_nxt = w_rd;
        w_occ_nxt      = r_out_occ;
        w_head_nxt     = r_head;
        w_skid_nxt     = r_skid;

        if (w_wr) begin
            w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? 7'd0 : r_wr_ptr + 7'd1;
        end
        if (w_rd) begin
            w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? 7'd0 : r_rd_ptr + 7'd1;
        end

        // Output stage: push is the data of last cycle's read.
        case ({r_inflight, w_pop})
            2'b11: begin
                if (r_out_occ == 2'd2) begin
                    w_head_nxt = r_skid;
                    w_skid_nxt = sram_dob;
                end else begin
                    w_head_nxt = sram_dob;
                end
            end
            2'b01: begin
                w_head_nxt = r_skid;
                w_occ_nxt  = r_out_occ - 2'd1;
            end
            2'b10: begin
                if (r_out_occ == 2'd0) begin
                    w_head_nxt = sram_dob;
                end else begin
                    w_skid_nxt = sram_dob;
                end
                w_occ_nxt = r_out_occ + 2'd1;
            end
            default: ;
        endcase

        if (flush) begin
            w_wr_ptr_nxt   = 7'd0;
            w_rd_ptr_nxt   = 7'd0;
            w_cnt_nxt      = 8'd0;
            w_inflight_nxt = 1'b0;
            w_occ_nxt      = 2'd0;
            w_head_nxt     = '0;
            w_skid_nxt     = '0;
        end

        w_level_nxt = w_cnt_nxt[6:0] + {6'd0, w_inflight_nxt} + {5'd0, w_occ_nxt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= 7'd0;
            r_rd_ptr   <= 7'd0;
            r_sram_cnt <= 8'd0;
            r_inflight <= 1'b0;
            r_out_occ  <= 2'd0;
            r_head     <= '0;
            r_skid     <= '0;
            r_level    <= 7'd0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_sram_cnt <= w_cnt_nxt;
            r_inflight <= w_inflight_nxt;
            r_out_occ  <= w_occ_nxt;
            r_head     <= w_head_nxt;
            r_skid     <= w_skid_nxt;
            r_level    <= w_level_nxt;
        end
    end

    // Equal pointers mean empty (no read) or full (no write), so a same-address
    // write/read pair can never be presented to the SRAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_no_collision: assert (!(w_wr && w_rd && (r_wr_ptr == r_rd_ptr)));
        end
    end

    // Outputs are forced to their idle values while rst is asserted.
    assign in_ready  = w_in_ready;
    assign out_valid = (r_out_occ != 2'd0) && !rst;
    assign out_data  = rst ? '0 : r_head;
    assign level     = rst ? 7'd0 : r_level;

    assign sram_a    = rst ? 7'd0 : r_wr_ptr;
    assign sram_wean = w_wr ? 8'h00 : 8'hFF;
    assign sram_dia  = rst ? '0 : in_data;
    assign sram_oea  = 1'b0;

    assign sram_b    = rst ? 7'd0 : r_rd_ptr;
    assign sram_webn = 8'hFF;
    assign sram_dib  = '0;
    assign sram_oeb  = w_rd;

endmodule
`default_nettype wire

// File: tb/tb_word72_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_word72_stream_ctrl
// Description : Directed self-checking bench for word72_stream_ctrl with a
//               behavioural dual-port SRAM and an in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word72_stream_ctrl;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, out_ready;
    logic [127:0] in_data;
    logic         in_ready, out_valid;
    logic [127:0] out_data;
    logic [6:0]   level, sram_a, sram_b;
    logic [7:0]   sram_wean, sram_webn;
    logic [127:0] sram_dia, sram_dib, sram_dob;
    logic         sram_oea, sram_oeb;

    int tests = 0;
    int fails = 0;
    int n_push = 0, n_pop = 0, n_rd = 0, n_coll = 0;
    logic [127:0] q[$];
    logic [127:0] mem [0:127];

    localparam logic [127:0] c_word = 128'hA5A5_5A5A_0123_4567_89AB_CDEF_FEDC_BA01;

    word72_stream_ctrl #(.DEPTH(72)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .sram_a(sram_a), .sram_wean(sram_wean), .sram_dia(sram_dia), .sram_oea(sram_oea),
        .sram_b(sram_b), .sram_webn(sram_webn), .sram_dib(sram_dib), .sram_oeb(sram_oeb),
        .sram_dob(sram_dob)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: port A writes, port B reads with one cycle latency.
    always @(posedge clk) begin
        if (sram_wean == 8'h00) mem[sram_a] <= sram_dia;
        if (sram_oeb) sram_dob <= mem[sram_b];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample handshakes just before the edge, then advance.
    task automatic cyc();
        #1;
        if (sram_wean == 8'h00 && sram_oeb && sram_a == sram_b) n_coll++;
        if (sram_oeb) n_rd++;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_pop++;
                if (q.size() == 0) chk("pop_on_empty", out_data, 128'hx);
                else chk("order", out_data, q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                n_push++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, rd0, pop0, push0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // ---- reset state ----
        cyc();
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_level", 128'(level), 128'd0);
        chk("rst_wean", 128'(sram_wean), 128'hFF);
        chk("rst_webn", 128'(sram_webn), 128'hFF);
        chk("rst_oeb", 128'(sram_oeb), 128'd0);
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);
        chk("post_rst_level", 128'(level), 128'd0);
        chk("post_rst_ptrs", {sram_a, sram_b}, 128'd0);

        // ---- single word, 3-cycle latency, level 1,1,1,0 ----
        out_ready = 1'b1; in_valid = 1'b1; in_data = c_word;
        #1;
        chk("sw_wean", 128'(sram_wean), 128'h00);
        chk("sw_dia", sram_dia, c_word);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("sw_c1_oeb", 128'(sram_oeb), 128'd1);
        chk("sw_c1_level", 128'(level), 128'd1);
        cyc();
        chk("sw_c2_valid", 128'(out_valid), 128'd0);
        chk("sw_c2_level", 128'(level), 128'd1);
        cyc();
        chk("sw_c3_valid", 128'(out_valid), 128'd1);
        chk("sw_c3_data", out_data, c_word);
        chk("sw_c3_level", 128'(level), 128'd1);
        cyc();
        chk("sw_c4_level", 128'(level), 128'd0);
        chk("sw_c4_valid", 128'(out_valid), 128'd0);

        // ---- fill with out_ready low: 72 in SRAM + 2 in output stage ----
        flush = 1'b1; out_ready = 1'b0;
        cyc();
        flush = 1'b0;
        #1;
        chk("flush_ptrs", {sram_a, sram_b}, 128'd0);
        rd0 = n_rd;
        for (int i = 0; i < 74; i++) begin
            in_valid = 1'b1; in_data = 128'(i);
            #1;
            chk("fill_in_ready", 128'(in_ready), 128'd1);
            cyc();
        end
        in_valid = 1'b1; in_data = 128'hBAD;
        #1;
        chk("full_in_ready", 128'(in_ready), 128'd0);
        chk("full_level", 128'(level), 128'd74);
        cyc();
        in_valid = 1'b0;
        cyc(); cyc();
        chk("full_reads", 128'(n_rd - rd0), 128'd2);
        chk("full_head_stable", out_data, 128'd0);
        chk("full_level_hold", 128'(level), 128'd74);

        // ---- drain: data 0..73, pointers wrap 71->0 ----
        pop0 = n_pop; n = 0;
        out_ready = 1'b1;
        while (level != 7'd0 && n < 300) begin cyc(); n++; end
        chk("drain_timeout", 128'(n < 300), 128'd1);
        chk("drain_pops", 128'(n_pop - pop0), 128'd74);
        chk("drain_rd_wrap", 128'(sram_b), 128'd2);
        chk("drain_wr_wrap", 128'(sram_a), 128'd2);
        chk("drain_in_ready", 128'(in_ready), 128'd1);

        // ---- throughput: 20-word burst drains in 23 cycles ----
        n = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 128'(1000 + i);
            cyc(); n++;
        end
        in_valid = 1'b0;
        while (level != 7'd0 && n < 100) begin cyc(); n++; end
        chk("burst_cycles", 128'(n), 128'd23);

        // ---- streaming 1000 words with random stalls ----
        push0 = n_push; pop0 = n_pop; n = 0;
        while ((n_pop - pop0) < 1000 && n < 8000) begin
            in_valid  = (n_push - push0) < 1000;
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            cyc(); n++;
        end
        in_valid = 1'b0;
        chk("stream_pops", 128'(n_pop - pop0), 128'd1000);
        chk("stream_q_empty", 128'(q.size()), 128'd0);
        chk("no_collision", 128'(n_coll), 128'd0);

        // ---- flush with 40 queued and a read in flight ----
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1; in_data = 128'(2000 + i);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("pre_flush_issue", 128'(sram_oeb), 128'd1);
        cyc();
        out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 128'hDEAD;
        #1;
        chk("flush_in_ready", 128'(in_ready), 128'd0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_level", 128'(level), 128'd0);
        chk("flush_valid", 128'(out_valid), 128'd0);
        chk("flush_ptrs0", {sram_a, sram_b}, 128'd0);
        in_valid = 1'b1; in_data = 128'h1234_5678; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc(); cyc();
        chk("post_flush_valid", 128'(out_valid), 128'd1);
        chk("post_flush_data", out_data, 128'h1234_5678);
        cyc();

        // ---- reset mid-stream at level 10 ----
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 128'(3000 + i);
            cyc();
        end
        in_valid = 1'b0;
        chk("pre_rst_level", 128'(level), 128'd10);
        rst = 1'b1; in_valid = 1'b1; in_data = 128'h77;
        #1;
        chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
        chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_level", 128'(level), 128'd0);
        chk("mid_rst_oeb", 128'(sram_oeb), 128'd0);
        chk("mid_rst_ab", {sram_a, sram_b}, 128'd0);
        chk("mid_rst_wean", 128'(sram_wean), 128'hFF);
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("after_rst_level", 128'(level), 128'd0);
        chk("after_rst_in_ready", 128'(in_ready), 128'd1);
        in_valid = 1'b1; in_data = 128'hCAFE; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc(); cyc();
        chk("after_rst_data", out_data, 128'hCAFE);
        chk("after_rst_valid", 128'(out_valid), 128'd1);
        cyc();
        chk("final_level", 128'(level), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
